// File: rtl/beat_period_estimator.sv
// Beat period estimator: turns baton direction-change flags into accepted beats and
// reports the mean of the last four accepted beat-to-beat intervals in camera clock cycles.
module beat_period_estimator #(
  parameter int COUNT_WIDTH  = 28,
  parameter int MIN_INTERVAL = 2_000_000,
  parameter int MAX_INTERVAL = 200_000_000
) (
  input  logic                   clk_camera_in,
  input  logic                   rst_in,
  input  logic                   beat_in,
  output logic                   beat_out,
  output logic [COUNT_WIDTH-1:0] period_out,
  output logic                   period_valid_out,
  output logic                   timeout_out
);

  localparam int SUM_W = COUNT_WIDTH + 2;
  localparam logic [COUNT_WIDTH-1:0] MIN_C = COUNT_WIDTH'(MIN_INTERVAL);
  localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_INTERVAL);

  typedef enum logic {S_IDLE, S_TIMING} state_t;

  function automatic logic [COUNT_WIDTH-1:0] f_sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (c >= MAX_C) ? MAX_C : c + COUNT_WIDTH'(1);
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] f_mean4(input logic [SUM_W-1:0] s);
    return COUNT_WIDTH'(s >> 2);
  endfunction

  state_t                 r_state;
  logic                   r_beat_d;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_hist [4];
  logic [1:0]             r_wptr;
  logic [2:0]             r_fill;
  logic [SUM_W-1:0]       r_sum;

  logic                   w_edge;
  logic                   w_timeout;
  logic                   w_accept;
  logic                   w_start;
  logic                   w_full;
  logic [COUNT_WIDTH-1:0] w_oldest;
  logic [SUM_W-1:0]       w_sum_next;

  // Timeout has priority; an edge in the timeout cycle becomes a fresh start.
  assign w_edge     = beat_in & ~r_beat_d;
  assign w_timeout  = (r_state == S_TIMING) && (r_count == MAX_C);
  assign w_accept   = (r_state == S_TIMING) && w_edge && !w_timeout &&
                      (r_count >= MIN_C) && (r_count < MAX_C);
  assign w_start    = w_edge && ((r_state == S_IDLE) || w_timeout);
  assign w_full     = (r_fill == 3'd4);
  assign w_oldest   = w_full ? r_hist[r_wptr] : '0;
  assign w_sum_next = r_sum - SUM_W'(w_oldest) + SUM_W'(r_count);

  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      r_state          <= S_IDLE;
      r_beat_d         <= 1'b0;
      r_count          <= '0;
      r_wptr           <= '0;
      r_fill           <= '0;
      r_sum            <= '0;
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      beat_out         <= 1'b0;
      timeout_out      <= 1'b0;
      period_out       <= '0;
      period_valid_out <= 1'b0;
    end else begin
      r_beat_d    <= beat_in;
      beat_out    <= w_start | w_accept;
      timeout_out <= w_timeout;

      // Stage 1: history/sum update; stage 2: registered mean from the updated sum.
      if (w_timeout) begin
        r_wptr           <= '0;
        r_fill           <= '0;
        r_sum            <= '0;
        for (int i = 0; i < 4; i++) r_hist[i] <= '0;
        period_out       <= '0;
        period_valid_out <= 1'b0;
      end else begin
        if (w_accept) begin
          r_hist[r_wptr] <= r_count;
          r_wptr         <= r_wptr + 2'd1;
          r_sum          <= w_sum_next;
          if (!w_full) r_fill <= r_fill + 3'd1;
        end
        period_valid_out <= w_full;
        period_out       <= w_full ? f_mean4(r_sum) : '0;
      end

      if (w_start || w_accept) begin
        r_state <= S_TIMING;
        r_count <= COUNT_WIDTH'(1);
      end else if (w_timeout) begin
        r_state <= S_IDLE;
        r_count <= '0;
      end else if (r_state == S_TIMING) begin
        r_count <= f_sat_inc(r_count);
      end
    end
  end

endmodule

// File: tb/tb_beat_period_estimator.sv
// Bench for beat_period_estimator: directed scenarios plus random beat trains, each cycle
// compared against an interval-list reference model.
module tb_beat_period_estimator;

  localparam int CW   = 8;
  localparam int MINI = 10;
  localparam int MAXI = 100;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          beat_in = 1'b0;
  logic          beat_out;
  logic [CW-1:0] period_out;
  logic          period_valid_out;
  logic          timeout_out;

  beat_period_estimator #(
    .COUNT_WIDTH (CW),
    .MIN_INTERVAL(MINI),
    .MAX_INTERVAL(MAXI)
  ) dut (
    .clk_camera_in   (clk),
    .rst_in          (rst_in),
    .beat_in         (beat_in),
    .beat_out        (beat_out),
    .period_out      (period_out),
    .period_valid_out(period_valid_out),
    .timeout_out     (timeout_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int nb    = 0;
  int nto   = 0;

  // Reference model: time of last accepted beat and the list of accepted intervals.
  int cyc       = 0;
  int m_last    = 0;
  bit m_started = 1'b0;
  bit m_prev    = 1'b0;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic b, input logic r);
    bit e_beat, e_to, e_valid, edge_s, to, acc, st;
    int e_per, d, s;
    beat_in = b;
    rst_in  = r;
    e_beat = 0; e_to = 0; e_valid = 0; e_per = 0;
    if (r) begin
      m_started = 0;
      m_prev    = 0;
      q.delete();
    end else begin
      edge_s = b && !m_prev;
      m_prev = b;
      d      = cyc - m_last;
      to     = m_started && (d == MAXI);
      acc    = m_started && !to && edge_s && (d >= MINI);
      st     = edge_s && (!m_started || to);
      e_beat = acc || st;
      e_to   = to;
      if (to) begin
        q.delete();
        m_started = 0;
      end else begin
        e_valid = (q.size() == 4);
        s = 0;
        foreach (q[i]) s += q[i];
        e_per = e_valid ? s / 4 : 0;
        if (acc) begin
          q.push_back(d);
          if (q.size() > 4) void'(q.pop_front());
        end
      end
      if (acc || st) begin
        m_started = 1;
        m_last    = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (beat_out === 1'b1) nb++;
    if (timeout_out === 1'b1) nto++;
    chk("beat_out", {31'b0, beat_out}, {31'b0, e_beat});
    chk("timeout_out", {31'b0, timeout_out}, {31'b0, e_to});
    chk("period_valid_out", {31'b0, period_valid_out}, {31'b0, e_valid});
    chk("period_out", {24'b0, period_out}, e_per);
  endtask

  task automatic beat(input int gap, input int width);
    for (int i = 0; i < gap; i++) step(i < width, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  int g, w, sel;

  initial begin
    // 1: reset held, then long quiet period
    step(0, 1); step(0, 1); step(0, 1);
    chk("rst_beat", {31'b0, beat_out}, 0);
    chk("rst_period", {24'b0, period_out}, 0);
    nb = 0; nto = 0;
    idle(99);
    chk("quiet_pulses", nb + nto, 0);

    // 2: five 1-cycle beats 40 apart
    nb = 0;
    for (int k = 0; k < 5; k++) beat(40, 1);
    chk("t2_beats", nb, 5);
    chk("t2_valid", {31'b0, period_valid_out}, 1);
    chk("t2_period", {24'b0, period_out}, 40);

    // 3: uneven intervals then one replacement
    step(0, 1);
    beat(20, 1); beat(40, 1); beat(60, 1); beat(80, 1);
    chk("t3_not_valid", {31'b0, period_valid_out}, 0);
    beat(30, 1);
    chk("t3_period50", {24'b0, period_out}, 50);
    beat(5, 1);
    chk("t3_period52", {24'b0, period_out}, 52);

    // 4: level-high beats
    step(0, 1);
    nb = 0;
    for (int k = 0; k < 5; k++) beat(40, 6);
    chk("t4_beats", nb, 5);
    chk("t4_period", {24'b0, period_out}, 40);

    // 5: refractory edge ignored
    step(0, 1);
    nb = 0;
    beat(5, 1); beat(35, 1);
    for (int k = 0; k < 4; k++) beat(40, 1);
    chk("t5_beats", nb, 5);
    chk("t5_valid", {31'b0, period_valid_out}, 1);
    chk("t5_period", {24'b0, period_out}, 40);

    // 6: silence timeout, restart, reset mid-interval
    nto = 0;
    idle(110);
    chk("t6_timeouts", nto, 1);
    chk("t6_valid", {31'b0, period_valid_out}, 0);
    chk("t6_period", {24'b0, period_out}, 0);
    beat(20, 1);
    step(0, 1);
    chk("t6_rst_beat", {31'b0, beat_out}, 0);
    chk("t6_rst_period", {24'b0, period_out}, 0);
    for (int k = 0; k < 4; k++) beat(40, 1);
    chk("t6_four_not_valid", {31'b0, period_valid_out}, 0);
    beat(40, 1);
    chk("t6_fifth_valid", {31'b0, period_valid_out}, 1);

    // edge landing exactly on the timeout cycle
    step(0, 1);
    nb = 0; nto = 0;
    beat(100, 1);
    for (int k = 0; k < 5; k++) beat(40, 1);
    chk("tc_timeouts", nto, 1);
    chk("tc_beats", nb, 6);
    chk("tc_period", {24'b0, period_out}, 40);

    // random beat trains with boundary-biased gaps and occasional resets
    step(0, 1);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) step(1'b1, 1'b1);
      sel = $urandom_range(0, 7);
      case (sel)
        0: g = MINI - 1;
        1: g = MINI;
        2: g = MINI + 1;
        3: g = MAXI - 1;
        4: g = MAXI;
        5: g = MAXI + 5;
        default: g = $urandom_range(2, 80);
      endcase
      w = $urandom_range(1, (g < 8) ? g : 8);
      beat(g, w);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
